// File: rtl/mem_line_arbiter.sv
// Purpose: round-robin owner of one single-port RAM, two requesters, WORDS-beat line bursts.
// Latency: grant the cycle after req is seen in IDLE; done after WORDS+2 (write) / WORDS+3 (read) cycles.
// Backpressure: the RAM never stalls; a losing requester simply holds req until its own done pulse.
//
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   rN_req/we/addr/wdata      requester N line request, direction, line address, write word[beat]
//   rN_gnt/rvalid/rdata/done  requester N ownership, read word strobe/data, end-of-burst pulse
//   beat, rbeat               shared issue index / index of the word on rN_rdata
//   mem_we/re/addr/data_in    RAM command port; mem_data_out is the registered RAM read data
module mem_line_arbiter #(
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic [ADDR_W-1:0]        r0_addr,
  input  logic [DATA_W-1:0]        r0_wdata,
  output logic                     r0_gnt,
  output logic                     r0_rvalid,
  output logic [DATA_W-1:0]        r0_rdata,
  output logic                     r0_done,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic [ADDR_W-1:0]        r1_addr,
  input  logic [DATA_W-1:0]        r1_wdata,
  output logic                     r1_gnt,
  output logic                     r1_rvalid,
  output logic [DATA_W-1:0]        r1_rdata,
  output logic                     r1_done,
  output logic [$clog2(WORDS)-1:0] beat,
  output logic [$clog2(WORDS)-1:0] rbeat,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out
);

  localparam int BEAT_W = $clog2(WORDS);
  localparam int LINE_W = $clog2(WORDS * 4);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q;     // 0 = requester 0, 1 = requester 1
  logic                last_gnt_q;  // most recent winner, used to break ties
  logic [ADDR_W-1:0]   base_q;
  logic [BEAT_W-1:0]   beat_q;

  logic                any_req;
  logic                pick;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic                rvalid_c;
  logic                done_c;
  logic                unused_line_bits;

  // Arbitration: a contested request goes to whoever did not win last time.
  assign any_req   = r0_req | r1_req;
  assign pick      = (r0_req & r1_req) ? ~last_gnt_q : r1_req;
  assign pick_we   = pick ? r1_we : r0_we;
  assign pick_addr = pick ? r1_addr : r0_addr;

  // Offset-within-line bits of the request address are deliberately discarded.
  assign unused_line_bits = ^pick_addr[LINE_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context: owner, direction is implied by state, line base and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      base_q     <= '0;
      beat_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q    <= pick;
            last_gnt_q <= pick;
            base_q     <= {pick_addr[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
            beat_q     <= '0;
          end
        end
        // beat stops at the last index so DRAIN keeps addressing the final word
        S_WRITE, S_READ: begin
          if (beat_q != BEAT_LAST) beat_q <= beat_q + BEAT_W'(1);
        end
        S_DONE:  beat_q <= '0;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = pick_we ? S_WRITE : S_READ;
      S_WRITE: if (beat_q == BEAT_LAST) state_d = S_DONE;
      S_READ:  if (beat_q == BEAT_LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: RAM command comes only from registered state; the write word
  // is the one combinational path, taken straight from the owner's wdata.
  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    rvalid_c    = 1'b0;
    rbeat       = '0;
    done_c      = 1'b0;
    case (state_q)
      S_WRITE: begin
        mem_we      = 1'b1;
        mem_addr    = base_q + ADDR_W'({beat_q, 2'b00});
        mem_data_in = owner_q ? r1_wdata : r0_wdata;
      end
      S_READ: begin
        mem_re   = 1'b1;
        mem_addr = base_q + ADDR_W'({beat_q, 2'b00});
        // RAM output is one cycle behind the issue, so word beat-1 is on the bus now
        if (beat_q != '0) begin
          rvalid_c = 1'b1;
          rbeat    = beat_q - BEAT_W'(1);
        end
      end
      S_DRAIN: begin
        // keep the last address presented so the RAM output stays on the final word
        mem_re   = 1'b1;
        mem_addr = base_q + ADDR_W'({beat_q, 2'b00});
        rvalid_c = 1'b1;
        rbeat    = BEAT_LAST;
      end
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  assign beat      = beat_q;
  assign r0_gnt    = (state_q != S_IDLE) & ~owner_q;
  assign r1_gnt    = (state_q != S_IDLE) &  owner_q;
  assign r0_rvalid = rvalid_c & ~owner_q;
  assign r1_rvalid = rvalid_c &  owner_q;
  assign r0_done   = done_c & ~owner_q;
  assign r1_done   = done_c &  owner_q;
  // Read data is shared; it is zeroed outside read delivery so idle/reset outputs are clean.
  assign r0_rdata  = rvalid_c ? mem_data_out : '0;
  assign r1_rdata  = rvalid_c ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;

  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic                    we;
    logic [31:0]             base;
    logic [WORDS-1:0][31:0]  data;
    logic                    chk_lat;
    logic [31:0]             issue_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic [$clog2(WORDS)-1:0] beat, rbeat;
  logic mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;

  logic [WORDS-1:0][31:0] drv_data0, drv_data1;
  logic        ram_init;
  logic [31:0] ram [0:127];
  logic [31:0] ref_mem [0:127];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  txn_t        exp_q0[$];
  txn_t        exp_q1[$];
  int          gnt_log[$];

  mem_line_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_done(r1_done),
    .beat(beat), .rbeat(rbeat),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requesters supply the word indexed by the shared beat output.
  assign r0_wdata = drv_data0[beat];
  assign r1_wdata = drv_data1[beat];

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0101);
  endfunction

  // RAM: synchronous write, registered read data.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr[8:2]] <= mem_data_in;
      if (mem_re) mem_data_out <= ram[mem_addr[8:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    txn_t cur;
    bit   active, pr0, pr1;
    int   own, exp_own, last_m, wk, ik, rk, gcyc, idx;
    logic rv, dn;
    logic [31:0] rd;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    active = 0; last_m = 1; pr0 = 0; pr1 = 0;
    own = 0; wk = 0; ik = 0; rk = 0; gcyc = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; last_m = 1; pr0 = 0; pr1 = 0;
        continue;
      end
      chk("we_re_exclusive", mem_we & mem_re, 0);
      chk("single_gnt", r0_gnt & r1_gnt, 0);
      if (!active) begin
        if (r0_gnt | r1_gnt) begin
          own = r1_gnt ? 1 : 0;
          chk("gnt_has_req", pr0 | pr1, 1);
          if (pr0 && pr1) exp_own = 1 - last_m;
          else            exp_own = pr1 ? 1 : 0;
          chk("rr_owner", own, exp_own);
          last_m = own;
          gnt_log.push_back(own);
          if ((own == 0 && exp_q0.size() == 0) || (own == 1 && exp_q1.size() == 0)) begin
            chk("txn_available", 0, 1);
            cur = '0;
          end else begin
            cur = (own == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          end
          active = 1; wk = 0; ik = 0; rk = 0; gcyc = cyc;
        end else begin
          chk("idle_quiet", {mem_we, mem_re, r0_rvalid, r1_rvalid, r0_done, r1_done}, 0);
        end
      end
      if (active) begin
        chk("owner_gnt", own ? r1_gnt : r0_gnt, 1);
        chk("nonowner_quiet", own ? {r0_gnt, r0_rvalid, r0_done} : {r1_gnt, r1_rvalid, r1_done}, 0);
        if (mem_we) begin
          chk("we_only_on_write", cur.we, 1);
          if (wk < WORDS) begin
            chk("wr_addr", mem_addr, cur.base + 32'(4 * wk));
            chk("wr_data", mem_data_in, cur.data[wk]);
            chk("wr_beat", beat, wk);
          end else begin
            chk("extra_write_beat", wk, WORDS - 1);
          end
          wk++;
        end
        if (mem_re) begin
          chk("re_only_on_read", cur.we, 0);
          chk("rd_addr", mem_addr, cur.base + 32'(4 * ((ik < WORDS) ? ik : WORDS - 1)));
          ik++;
        end
        rv = own ? r1_rvalid : r0_rvalid;
        rd = own ? r1_rdata : r0_rdata;
        if (rv) begin
          chk("rd_rbeat", rbeat, rk);
          idx = (int'(cur.base[8:2]) + rk) % 128;
          chk("rd_data", rd, ref_mem[idx]);
          rk++;
        end
        dn = own ? r1_done : r0_done;
        if (dn) begin
          if (cur.we) begin
            chk("wr_beat_count", wk, WORDS);
            chk("wr_no_rvalid", rk, 0);
            for (int w = 0; w < WORDS; w++) ref_mem[(int'(cur.base[8:2]) + w) % 128] = cur.data[w];
          end else begin
            chk("rd_word_count", rk, WORDS);
            chk("rd_issue_count", ik, WORDS + 1);
          end
          chk("gnt_to_done", cyc - gcyc, cur.we ? WORDS : WORDS + 1);
          if (cur.chk_lat)
            chk("req_to_done", cyc - int'(cur.issue_cyc) + 1, cur.we ? WORDS + 2 : WORDS + 3);
          active = 0;
        end
      end
      pr0 = r0_req;
      pr1 = r1_req;
    end
  end

  task automatic do_req(input int n, input bit we, input logic [31:0] addr,
                        input logic [WORDS-1:0][31:0] d, input int drop_at, input bit chk_lat);
    txn_t t;
    bit   seen, dropped;
    @(posedge clk); #1;
    t.we = we;
    t.base = addr & ~32'(WORDS * 4 - 1);
    t.data = d;
    t.chk_lat = chk_lat;
    t.issue_cyc = 32'(cyc);
    if (n == 0) begin
      drv_data0 = d; r0_we = we; r0_addr = addr; r0_req = 1'b1; exp_q0.push_back(t);
    end else begin
      drv_data1 = d; r1_we = we; r1_addr = addr; r1_req = 1'b1; exp_q1.push_back(t);
    end
    seen = 0; dropped = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((n == 0) ? r0_done : r1_done) begin
        seen = 1;
        break;
      end
      if (!dropped && drop_at >= 0 && ((n == 0) ? r0_gnt : r1_gnt) && int'(beat) == drop_at) begin
        @(posedge clk); #1;
        if (n == 0) r0_req = 1'b0; else r1_req = 1'b0;
        dropped = 1;
      end
    end
    chk((n == 0) ? "r0_done_seen" : "r1_done_seen", seen, 1);
    @(posedge clk); #1;
    if (n == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic rand_stream(input int n, input int count);
    for (int t = 0; t < count; t++) begin
      int gap, drop;
      logic [31:0] a;
      logic [WORDS-1:0][31:0] d;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      a = 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
      for (int w = 0; w < WORDS; w++) d[w] = $urandom;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      do_req(n, bit'($urandom_range(0, 1)), a, d, drop, 1'b0);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [WORDS-1:0][31:0] da, dz, dd;
    int exp_seq[7];
    bit found;
    exp_seq = '{0, 1, 0, 1, 1, 0, 1};
    rst = 1'b1; ram_init = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r1_req = 0; r1_we = 0; r1_addr = '0;
    drv_data0 = '0; drv_data1 = '0;
    for (int w = 0; w < WORDS; w++) begin
      da[w] = 32'hA000_0000 + 32'(w);
      dd[w] = 32'hD0D0_0000 + 32'(w * 17);
    end
    dz = '0;
    @(posedge clk); #1 ram_init = 1'b0;
    @(negedge clk);
    chk("reset_gnt", {r0_gnt, r1_gnt}, 0);
    chk("reset_flags", {r0_rvalid, r1_rvalid, r0_done, r1_done, mem_we, mem_re}, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_beats", {beat, rbeat}, 0);
    chk("reset_mem_wdata", mem_data_in, 0);
    #1 rst = 1'b0;

    // line write then read-back through the other requester
    do_req(0, 1'b1, 32'h103, da, -1, 1'b1);
    do_req(1, 1'b0, 32'h100, dz, -1, 1'b1);

    // round-robin ordering from a fresh reset
    reset_pulse();
    gnt_log.delete();
    fork
      do_req(0, 1'b1, 32'h20, da, -1, 1'b0);
      do_req(1, 1'b0, 32'h20, dz, -1, 1'b0);
    join
    fork
      do_req(0, 1'b0, 32'h30, dz, -1, 1'b0);
      do_req(1, 1'b1, 32'h34, dd, -1, 1'b0);
    join
    do_req(1, 1'b0, 32'h10, dz, -1, 1'b1);
    fork
      do_req(0, 1'b0, 32'h30, dz, -1, 1'b0);
      do_req(1, 1'b0, 32'h20, dz, -1, 1'b0);
    join
    chk("rr_log_len", gnt_log.size(), 7);
    for (int i = 0; i < 7 && i < gnt_log.size(); i++) chk("rr_log_entry", gnt_log[i], exp_seq[i]);

    // asynchronous reset in the middle of a write burst
    @(posedge clk); #1;
    drv_data0 = dd; r0_we = 1'b1; r0_addr = 32'h48; r0_req = 1'b1;
    exp_q0.push_back('{we: 1'b1, base: 32'h40, data: dd, chk_lat: 1'b0, issue_cyc: 32'(cyc)});
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we && beat == 2) begin
        found = 1;
        break;
      end
    end
    chk("abort_reached_beat2", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_flags", {r0_gnt, r1_gnt, r0_done, r1_done, r0_rvalid, r1_rvalid, mem_we, mem_re}, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_beats", {beat, rbeat}, 0);
    chk("async_rst_wdata", mem_data_in, 0);
    r0_req = 1'b0;
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    do_req(0, 1'b1, 32'h48, dd, -1, 1'b1);

    // requester drops req after beat 1 of a read
    do_req(0, 1'b0, 32'h4C, dz, 1, 1'b1);

    // random mixed traffic
    fork
      rand_stream(0, 25);
      rand_stream(1, 25);
    join
    repeat (4) @(posedge clk);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
